// File: rtl/ray_gen_dispatcher_pkg.sv
// Shared types for the ray generator dispatcher: fixed-point vec3, FSM and slot states.
// Display geometry macros fall back to a small default when not supplied by the build.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 4
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 2
`endif
`ifndef H_BITS
`define H_BITS 4
`endif
`ifndef V_BITS
`define V_BITS 4
`endif

package ray_gen_dispatcher_pkg;
    localparam int FP_W   = 16;
    localparam int VEC3_W = 3 * FP_W;

    typedef logic [FP_W-1:0] fp_t;
    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} disp_state_e;
    typedef enum logic [1:0] {SLOT_EMPTY, SLOT_PENDING, SLOT_FULL} slot_state_e;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ray_gen_lane_slot.sv
// One result slot per lane: remembers the issued pixel, captures the lane's
// direction pulse, and empties when the retire side drains it.
module ray_gen_lane_slot
    import ray_gen_dispatcher_pkg::*;
#(
    parameter int H_BITS = 4,
    parameter int V_BITS = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              i_issue,
    input  logic [H_BITS-1:0] i_hcount,
    input  logic [V_BITS-1:0] i_vcount,
    input  logic              i_capture,
    input  logic [VEC3_W-1:0] i_dir,
    input  logic              i_drain,
    output slot_state_e       o_state,
    output logic [H_BITS-1:0] o_hcount,
    output logic [V_BITS-1:0] o_vcount,
    output logic [VEC3_W-1:0] o_dir
);
    slot_state_e       r_state;
    logic [H_BITS-1:0] r_hcount;
    logic [V_BITS-1:0] r_vcount;
    logic [VEC3_W-1:0] r_dir;

    // Issue wins over drain so a same-cycle retire/reissue leaves the slot pending.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= SLOT_EMPTY;
            r_hcount <= '0;
            r_vcount <= '0;
            r_dir    <= '0;
        end else if (i_issue) begin
            r_state  <= SLOT_PENDING;
            r_hcount <= i_hcount;
            r_vcount <= i_vcount;
        end else if (i_capture && r_state == SLOT_PENDING) begin
            r_state <= SLOT_FULL;
            r_dir   <= i_dir;
        end else if (i_drain && r_state == SLOT_FULL) begin
            r_state <= SLOT_EMPTY;
        end
    end

    assign o_state  = r_state;
    assign o_hcount = r_hcount;
    assign o_vcount = r_vcount;
    assign o_dir    = r_dir;
endmodule

// File: rtl/ray_gen_dispatcher.sv
// Raster-order pixel scheduler for NUM_LANES ray generators with in-order retire.
// Optional stall counter output enabled by defining RAY_GEN_DISPATCH_PERF_EN.
module ray_gen_dispatcher
    import ray_gen_dispatcher_pkg::*;
#(
    parameter int NUM_LANES      = 2,
    parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
    parameter int H_BITS         = `H_BITS,
    parameter int V_BITS         = `V_BITS
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic [VEC3_W-1:0]           cam_forward_in,
    output logic [NUM_LANES-1:0]        gen_valid_out,
    output logic [H_BITS-1:0]           gen_hcount_out,
    output logic [V_BITS-1:0]           gen_vcount_out,
    output logic [VEC3_W-1:0]           gen_cam_forward_out,
    input  logic [NUM_LANES-1:0]        gen_ready_in,
    input  logic [NUM_LANES-1:0]        gen_valid_in,
    input  logic [NUM_LANES*VEC3_W-1:0] gen_dir_in,
    output logic                        ray_valid_out,
    input  logic                        ray_ready_in,
    output logic [H_BITS-1:0]           ray_hcount_out,
    output logic [V_BITS-1:0]           ray_vcount_out,
    output logic [VEC3_W-1:0]           ray_dir_out,
    output logic                        busy_out,
    output logic                        frame_done_out
`ifdef RAY_GEN_DISPATCH_PERF_EN
    ,
    output logic [31:0]                 stall_cycles_out
`endif
);
    localparam int                PW        = ptr_w(NUM_LANES);
    localparam logic [PW-1:0]     LAST_LANE = PW'(NUM_LANES - 1);
    localparam logic [H_BITS-1:0] H_LAST    = H_BITS'(DISPLAY_WIDTH - 1);
    localparam logic [V_BITS-1:0] V_LAST    = V_BITS'(DISPLAY_HEIGHT - 1);

    disp_state_e       r_state, w_state_nxt;
    logic [PW-1:0]     r_iptr, r_rptr;
    logic [H_BITS-1:0] r_hcount;
    logic [V_BITS-1:0] r_vcount;
    vec3_t             r_cam;

    logic [NUM_LANES-1:0]             w_empty, w_full, w_isel, w_rsel, w_issue, w_drain;
    logic [NUM_LANES-1:0][H_BITS-1:0] w_slot_h;
    logic [NUM_LANES-1:0][V_BITS-1:0] w_slot_v;
    logic [NUM_LANES-1:0][VEC3_W-1:0] w_slot_dir;
    logic w_start, w_issue_ok, w_retire, w_last_pix, w_all_empty;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        slot_state_e w_st;

        assign w_isel[g]  = (r_iptr == PW'(g));
        assign w_rsel[g]  = (r_rptr == PW'(g));
        assign w_issue[g] = w_isel[g] & w_issue_ok;
        assign w_drain[g] = w_rsel[g] & w_retire;
        assign w_empty[g] = (w_st == SLOT_EMPTY);
        assign w_full[g]  = (w_st == SLOT_FULL);

        ray_gen_lane_slot #(
            .H_BITS (H_BITS),
            .V_BITS (V_BITS)
        ) u_slot (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .i_issue   (w_issue[g]),
            .i_hcount  (r_hcount),
            .i_vcount  (r_vcount),
            .i_capture (gen_valid_in[g]),
            .i_dir     (gen_dir_in[g*VEC3_W +: VEC3_W]),
            .i_drain   (w_drain[g]),
            .o_state   (w_st),
            .o_hcount  (w_slot_h[g]),
            .o_vcount  (w_slot_v[g]),
            .o_dir     (w_slot_dir[g])
        );
    end

    always_comb begin
        ray_valid_out  = 1'b0;
        ray_hcount_out = '0;
        ray_vcount_out = '0;
        ray_dir_out    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_rsel[i]) begin
                ray_valid_out  = w_full[i];
                ray_hcount_out = w_slot_h[i];
                ray_vcount_out = w_slot_v[i];
                ray_dir_out    = w_slot_dir[i];
            end
        end
    end

    assign w_retire = ray_valid_out && ray_ready_in;

    // A full slot being retired this cycle counts as free, so the lane keeps streaming.
    always_comb begin
        w_issue_ok = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_isel[i]) begin
                w_issue_ok = (r_state == ST_RUN) && gen_ready_in[i] &&
                             (w_empty[i] || (w_full[i] && w_drain[i]));
            end
        end
    end

    assign w_start     = (r_state == ST_IDLE) && start_in;
    assign w_last_pix  = (r_hcount == H_LAST) && (r_vcount == V_LAST);
    assign w_all_empty = &w_empty;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start_in) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_issue_ok && w_last_pix) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_all_empty) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= ST_IDLE;
            r_iptr   <= '0;
            r_rptr   <= '0;
            r_hcount <= '0;
            r_vcount <= '0;
            r_cam    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cam    <= cam_forward_in;
                r_iptr   <= '0;
                r_rptr   <= '0;
                r_hcount <= '0;
                r_vcount <= '0;
            end else begin
                if (w_issue_ok) begin
                    r_iptr <= (r_iptr == LAST_LANE) ? '0 : r_iptr + 1'b1;
                    if (r_hcount == H_LAST) begin
                        r_hcount <= '0;
                        r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
                    end else begin
                        r_hcount <= r_hcount + 1'b1;
                    end
                end
                if (w_retire) r_rptr <= (r_rptr == LAST_LANE) ? '0 : r_rptr + 1'b1;
            end
        end
    end

    assign gen_valid_out       = w_issue;
    assign gen_hcount_out      = r_hcount;
    assign gen_vcount_out      = r_vcount;
    assign gen_cam_forward_out = r_cam;
    assign busy_out            = (r_state != ST_IDLE);
    assign frame_done_out      = (r_state == ST_DONE);

`ifdef RAY_GEN_DISPATCH_PERF_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_stall <= '0;
        end else if (w_start) begin
            r_stall <= '0;
        end else if (r_state == ST_RUN && !w_issue_ok && r_stall != '1) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles_out = r_stall;
`endif
endmodule

// File: tb/tb_ray_gen_dispatcher.sv
// Randomized bench: lane models with configurable latency feed the dispatcher and a
// frame-level model predicts issue, retire order, data and frame handshakes each cycle.
module tb_ray_gen_dispatcher;
    import ray_gen_dispatcher_pkg::*;

`ifdef RAY_GEN_DISPATCH_PERF_EN
    localparam int N = 1, W = 2, H = 1, LAT_A = 10;
`else
    localparam int N = 2, W = 4, H = 2, LAT_A = 7;
`endif
    localparam int HB = 4, VB = 4, VW = VEC3_W, TOTAL = W * H;
    localparam int RST_AT = (TOTAL > 3) ? 3 : 1;
    localparam logic [VW-1:0] CAM_A = 48'h1111_2222_3333;
    localparam logic [VW-1:0] CAM_B = 48'hdead_beef_0f0f;
    localparam logic [VW-1:0] CAM_C = 48'h0abc_1234_5a5a;

    logic            clk_in = 1'b0;
    logic            rst_in, start_in, ray_ready_in;
    logic [VW-1:0]   cam_forward_in;
    logic [N-1:0]    gen_valid_out, gen_ready_in, gen_valid_in;
    logic [HB-1:0]   gen_hcount_out, ray_hcount_out;
    logic [VB-1:0]   gen_vcount_out, ray_vcount_out;
    logic [VW-1:0]   gen_cam_forward_out, ray_dir_out;
    logic [N*VW-1:0] gen_dir_in;
    logic            ray_valid_out, busy_out, frame_done_out;
`ifdef RAY_GEN_DISPATCH_PERF_EN
    logic [31:0]     stall_cycles_out;
`endif

    always #5 clk_in = ~clk_in;

    ray_gen_dispatcher #(
        .NUM_LANES(N), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .cam_forward_in(cam_forward_in),
        .gen_valid_out(gen_valid_out), .gen_hcount_out(gen_hcount_out),
        .gen_vcount_out(gen_vcount_out), .gen_cam_forward_out(gen_cam_forward_out),
        .gen_ready_in(gen_ready_in), .gen_valid_in(gen_valid_in), .gen_dir_in(gen_dir_in),
        .ray_valid_out(ray_valid_out), .ray_ready_in(ray_ready_in),
        .ray_hcount_out(ray_hcount_out), .ray_vcount_out(ray_vcount_out),
        .ray_dir_out(ray_dir_out), .busy_out(busy_out), .frame_done_out(frame_done_out)
`ifdef RAY_GEN_DISPATCH_PERF_EN
        , .stall_cycles_out(stall_cycles_out)
`endif
    );

    int total_n = 0, bad_n = 0;

    // Lane models: one ray in flight per lane, result pulse lat cycles after issue.
    int            lcnt[N], lat[N], lh[N], lv[N];
    logic [VW-1:0] lcam[N];
    int            rr_pct = 100, hold_cnt = 0;

    // Frame-level model state.
    bit            m_busy, m_run, m_fd;
    int            m_iss, m_ret, fd_cnt;
    bit            m_occ[N], m_done[N];
    logic [VW-1:0] m_cam;
    int unsigned   m_stall;
    logic [VW-1:0] first_dir, last_dir;
    logic [HB-1:0] last_h;
    logic [VB-1:0] last_v;

    function automatic logic [VW-1:0] ray_dir(input int h, input int v, input logic [VW-1:0] cam);
        logic [15:0] a, b, c;
        a = 16'(h * 37 + v * 5 + 1);
        b = 16'(v * 11 + h * 3);
        c = cam[15:0] ^ 16'(h + v * 256);
        return {a, b, c};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_run = 0; m_fd = 0; m_iss = 0; m_ret = 0;
        m_cam = '0; m_stall = 0;
        for (int i = 0; i < N; i++) begin
            m_occ[i] = 0; m_done[i] = 0; lcnt[i] = 0;
        end
        gen_valid_in = '0;
        gen_ready_in = '1;
    endtask

    // Runs at the falling edge: compares DUT outputs with the model, then advances
    // the model by the events that the coming rising edge will commit.
    task automatic check_and_update();
        int head, il;
        bit rv_e, ret, iss_e, nfd, run_now, busy_now;
        logic [N-1:0] exp_gv;
        if (rst_in) begin
            chk("reset_outs", {gen_valid_out, ray_valid_out, busy_out, frame_done_out}, 0);
            return;
        end
        head = m_ret % N;
        il   = m_iss % N;
        rv_e = m_busy && m_ret < TOTAL && m_done[head];
        chk("ray_valid", ray_valid_out, rv_e);
        if (rv_e) begin
            chk("ray_xy", {ray_hcount_out, ray_vcount_out}, {HB'(m_ret % W), VB'(m_ret / W)});
            chk("ray_dir", ray_dir_out, ray_dir(m_ret % W, m_ret / W, m_cam));
        end
        ret   = rv_e && ray_ready_in;
        iss_e = m_run && gen_ready_in[il] && (!m_occ[il] || (il == head && ret));
        exp_gv = '0;
        if (iss_e) exp_gv[il] = 1'b1;
        chk("gen_valid", gen_valid_out, exp_gv);
        if (iss_e) chk("issue_xy", {gen_hcount_out, gen_vcount_out}, {HB'(m_iss % W), VB'(m_iss / W)});
        chk("busy", busy_out, m_busy);
        chk("frame_done", frame_done_out, m_fd);
        chk("cam", gen_cam_forward_out, m_cam);
`ifdef RAY_GEN_DISPATCH_PERF_EN
        chk("stall", stall_cycles_out, m_stall);
`endif
        if (frame_done_out) fd_cnt++;
        if (ret && m_ret == 0) first_dir = ray_dir_out;
        if (ret && m_ret == TOTAL - 1) begin
            last_dir = ray_dir_out; last_h = ray_hcount_out; last_v = ray_vcount_out;
        end
        // lanes react to what the DUT actually issues
        for (int i = 0; i < N; i++) begin
            if (gen_valid_out[i]) begin
                lcnt[i] = lat[i]; lh[i] = int'(gen_hcount_out); lv[i] = int'(gen_vcount_out);
                lcam[i] = gen_cam_forward_out;
            end
        end
        run_now  = m_run;
        busy_now = m_busy;
        nfd = m_busy && !m_fd && m_ret == TOTAL;
        for (int i = 0; i < N; i++)
            if (gen_valid_in[i] && m_occ[i] && !m_done[i]) m_done[i] = 1;
        if (ret) begin
            m_done[head] = 0; m_occ[head] = 0; m_ret++;
        end
        if (iss_e) begin
            m_occ[il] = 1; m_iss++;
            if (m_iss == TOTAL) m_run = 0;
        end
        if (run_now && !iss_e && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (m_fd) m_busy = 0;
        m_fd = nfd;
        if (start_in && !busy_now) begin
            m_busy = 1; m_run = 1; m_iss = 0; m_ret = 0; m_cam = cam_forward_in; m_stall = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            gen_valid_in[i] = 1'b0;
            if (lcnt[i] > 0) begin
                lcnt[i]--;
                if (lcnt[i] == 0) begin
                    gen_valid_in[i] = 1'b1;
                    gen_dir_in[i*VW +: VW] = ray_dir(lh[i], lv[i], lcam[i]);
                end
            end
            gen_ready_in[i] = (lcnt[i] == 0);
        end
        start_in = 1'b0;
        if (hold_cnt > 0) begin
            ray_ready_in = 1'b0;
            hold_cnt--;
        end else begin
            ray_ready_in = ($urandom_range(99) < rr_pct);
        end
    endtask

    task automatic cycle();
        @(negedge clk_in);
        check_and_update();
        @(posedge clk_in);
        #1;
        drive();
    endtask

    task automatic set_lat(input int a, input int b);
        for (int i = 0; i < N; i++) lat[i] = $urandom_range(9, 1);
        lat[0] = a;
        if (N > 1) lat[1] = b;
    endtask

    task automatic reset_mid();
        rst_in = 1'b1;
        #1;
        chk("rst_gen_valid", gen_valid_out, 0);
        chk("rst_gen_xy", {gen_hcount_out, gen_vcount_out}, 0);
        chk("rst_cam", gen_cam_forward_out, 0);
        chk("rst_ray", {ray_valid_out, ray_hcount_out, ray_vcount_out}, 0);
        chk("rst_ray_dir", ray_dir_out, 0);
        chk("rst_busy_done", {busy_out, frame_done_out}, 0);
`ifdef RAY_GEN_DISPATCH_PERF_EN
        chk("rst_stall", stall_cycles_out, 0);
`endif
        model_reset();
        cycle();
        cycle();
        rst_in = 1'b0;
    endtask

    task automatic run_frame(input logic [VW-1:0] cam, input int rr, input bit do_hold,
                             input bit do_restart, input bit do_reset);
        bit fin, held, restarted;
        fin = 0; held = 0; restarted = 0; fd_cnt = 0; rr_pct = rr;
        start_in = 1'b1;
        cam_forward_in = cam;
        for (int c = 0; c < 3000 && !fin; c++) begin
            cycle();
            if (do_hold && !held && m_busy && m_ret >= TOTAL / 4) begin
                held = 1; hold_cnt = 20;
            end
            if (do_restart && !restarted && m_busy && m_iss >= TOTAL / 2) begin
                start_in = 1'b1; cam_forward_in = CAM_B; restarted = 1;
            end
            if (do_reset && m_ret >= RST_AT) begin
                reset_mid();
                return;
            end
            if (fd_cnt > 0 && !m_busy) fin = 1;
        end
        chk("frame_finished", fin, 1);
        chk("frame_rays", m_ret, TOTAL);
        chk("frame_done_pulses", fd_cnt, 1);
        chk("busy_after", busy_out, 0);
    endtask

    initial begin
        rst_in = 1'b1; start_in = 1'b0; ray_ready_in = 1'b1;
        cam_forward_in = '0; gen_dir_in = '0;
        set_lat(LAT_A, LAT_A);
        model_reset();
        repeat (3) cycle();
        rst_in = 1'b0;
        chk("init_outs", {gen_valid_out, gen_hcount_out, gen_vcount_out, ray_valid_out,
                          busy_out, frame_done_out}, 0);
        chk("init_cam_dir", {gen_cam_forward_out, 16'h0} | 64'(ray_dir_out), 0);
        repeat (2) cycle();

        // fixed latency, always-ready sink; model pinned with literal rays
        set_lat(LAT_A, LAT_A);
        run_frame(CAM_A, 100, 0, 0, 0);
        chk("A_first_dir", first_dir, 48'h0001_0000_3333);
`ifdef RAY_GEN_DISPATCH_PERF_EN
        chk("A_last_xy", {last_h, last_v}, {4'd1, 4'd0});
        chk("A_last_dir", last_dir, 48'h0026_0003_3332);
        chk("A_stall", stall_cycles_out, 10);
`else
        chk("A_last_xy", {last_h, last_v}, {4'd3, 4'd1});
        chk("A_last_dir", last_dir, 48'h0075_0014_3230);
`endif
        repeat (2) cycle();

        // unequal lane latencies, then with a random sink
        set_lat(3, 12);
        run_frame(CAM_C, 100, 0, 0, 0);
        run_frame(CAM_A ^ CAM_C, 70, 0, 0, 0);

        // sink stalled for 20 cycles and a start pulse ignored mid-frame
        set_lat(4, 5);
        run_frame(CAM_C, 100, 1, 1, 0);

        // reset after a few retired rays, then a clean restart from (0,0)
        set_lat(6, 2);
        run_frame(CAM_B, 100, 0, 0, 1);
        repeat (2) cycle();
        set_lat(LAT_A, 3);
        run_frame(CAM_A, 100, 0, 0, 0);

        for (int f = 0; f < 3; f++) begin
            set_lat($urandom_range(9, 1), $urandom_range(9, 1));
            run_frame({$urandom, 16'($urandom)}, $urandom_range(100, 40), 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
